// File: rtl/stopwatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_ctrl_pkg
// Brief  : State codes and output bundle shared by the stopwatch control path
// Rev    : 1.0  initial release
// ============================================================================
package stopwatch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LAP  = 2'b10;
  localparam logic [1:0] ST_STOP = 2'b11;

  typedef struct packed {
    logic enable;
    logic reset_counter;
    logic display_hold;
    logic lap_capture;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_RESET = '{enable: 1'b0, reset_counter: 1'b1,
                                           display_hold: 1'b0, lap_capture: 1'b0};

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module : key_debounce
// Brief  : 2-flop synchroniser, counter debounce and 1-cycle press pulse
// Rev    : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          db;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != db) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      // Pulse on the same edge the debounced level falls, not one later.
      press <= accept && !sync2;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (accept) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_ctrl
// Brief  : Debounced key FSM driving counter enable/clear and display hold/lap
// Rev    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_reset_n,
  output logic       enable,
  output logic       reset_counter,
  output logic       display_hold,
  output logic       lap_capture,
  output logic [1:0] state
);

  logic press_start;
  logic press_lap;
  logic press_reset;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .key_n(key_start_n), .press(press_start)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .key_n(key_lap_n), .press(press_lap)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk(clk), .rst_n(rst_n), .key_n(key_reset_n), .press(press_reset)
  );

  logic [1:0] state_q;
  logic [1:0] state_d;
  ctrl_out_t  outs_q;
  ctrl_out_t  outs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      outs_q  <= CTRL_OUT_RESET;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

  // Per-state if/else chain: only presses valid in the state are listed,
  // so the highest-priority valid press wins (start > reset > lap).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (press_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_start)    state_d = ST_STOP;
        else if (press_lap) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (press_start)    state_d = ST_STOP;
        else if (press_lap) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (press_start)      state_d = ST_RUN;
        else if (press_reset) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    outs_d               = CTRL_OUT_RESET;
    outs_d.enable        = (state_d == ST_RUN) || (state_d == ST_LAP);
    outs_d.reset_counter = (state_d == ST_IDLE);
    outs_d.display_hold  = (state_d == ST_LAP);
    outs_d.lap_capture   = (state_q == ST_RUN) && (state_d == ST_LAP);
  end

  assign state         = state_q;
  assign enable        = outs_q.enable;
  assign reset_counter = outs_q.reset_counter;
  assign display_hold  = outs_q.display_hold;
  assign lap_capture   = outs_q.lap_capture;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_stopwatch_ctrl
// Brief  : Directed self-checking bench for stopwatch_ctrl (DB_CYCLES = 3)
// Rev    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] LAP  = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_lap_n = 1'b1;
  logic       key_reset_n = 1'b1;
  logic       enable;
  logic       reset_counter;
  logic       display_hold;
  logic       lap_capture;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_ctrl #(.DB_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start_n(key_start_n), .key_lap_n(key_lap_n), .key_reset_n(key_reset_n),
    .enable(enable), .reset_counter(reset_counter), .display_hold(display_hold),
    .lap_capture(lap_capture), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic en,
                            input logic rc, input logic dh, input logic lc);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
    chk({tag, ".enable"}, {7'd0, enable}, {7'd0, en});
    chk({tag, ".reset_counter"}, {7'd0, reset_counter}, {7'd0, rc});
    chk({tag, ".display_hold"}, {7'd0, display_hold}, {7'd0, dh});
    chk({tag, ".lap_capture"}, {7'd0, lap_capture}, {7'd0, lc});
  endtask

  // Hold the selected keys low for 10 edges, release, then let things settle.
  task automatic press(input logic s, input logic l, input logic r);
    key_start_n = ~s;
    key_lap_n   = ~l;
    key_reset_n = ~r;
    ticks(10);
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    key_reset_n = 1'b1;
    ticks(8);
  endtask

  initial begin
    // 1. reset
    ticks(2);
    check_outs("reset", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    ticks(3);
    check_outs("idle", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3a. bounce shorter than the debounce window is rejected
    for (int i = 0; i < 8; i++) begin
      key_start_n = i[0];
      tick();
    end
    key_start_n = 1'b1;
    ticks(8);
    check_outs("bounce", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2. latency: state changes exactly after edge 6, once
    key_start_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e >= 6) check_outs($sformatf("start_e%0d", e), RUN, 1'b1, 1'b0, 1'b0, 1'b0);
      else        check_outs($sformatf("start_e%0d", e), IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    key_start_n = 1'b1;
    ticks(8);
    check_outs("start_release", RUN, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4. RUN -> LAP with one-cycle capture strobe
    key_lap_n = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e >= 6) check_outs($sformatf("lap_e%0d", e), LAP, 1'b1, 1'b0, 1'b1, (e == 6));
      else        check_outs($sformatf("lap_e%0d", e), RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    key_lap_n = 1'b1;
    ticks(8);
    check_outs("lap_hold", LAP, 1'b1, 1'b0, 1'b1, 1'b0);

    // LAP -> RUN, no capture strobe
    key_lap_n = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e >= 6) check_outs($sformatf("unlap_e%0d", e), RUN, 1'b1, 1'b0, 1'b0, 1'b0);
      else        check_outs($sformatf("unlap_e%0d", e), LAP, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    key_lap_n = 1'b1;
    ticks(8);

    // RUN: start and lap together -> start wins, no capture
    press(1'b1, 1'b1, 1'b0);
    check_outs("run_start_lap", STOP, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5. STOP: start + reset together -> RUN, counter clear never asserted
    key_start_n = 1'b0;
    key_reset_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("stop_sr_e%0d.reset_counter", e), {7'd0, reset_counter}, 8'd0);
      chk($sformatf("stop_sr_e%0d.state", e), {6'd0, state}, (e >= 6) ? {6'd0, RUN} : {6'd0, STOP});
    end
    key_start_n = 1'b1;
    key_reset_n = 1'b1;
    ticks(8);

    // RUN: reset ignored
    press(1'b0, 1'b0, 1'b1);
    check_outs("run_reset_ignored", RUN, 1'b1, 1'b0, 1'b0, 1'b0);

    // RUN -> STOP -> reset -> IDLE
    press(1'b1, 1'b0, 1'b0);
    check_outs("run_stop", STOP, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_outs("stop_lap_ignored", STOP, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check_outs("stop_reset", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_outs("idle_lap_ignored", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);

    // 6. reset from LAP, with start held through reset
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_outs("pre_reset_lap", LAP, 1'b1, 1'b0, 1'b1, 1'b0);
    key_start_n = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outs("mid_reset", IDLE, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("held_reset_e%0d.state", e), {6'd0, state}, (e >= 6) ? {6'd0, RUN} : {6'd0, IDLE});
    end
    key_start_n = 1'b1;
    ticks(8);
    check_outs("held_reset_final", RUN, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
